// File: rtl/drc_pxl_pkg.sv
// Shared types and constants for the DVP RX pixel format controller.
// State encoding, mode constants and fixed pixel widths.
package drc_pxl_pkg;

  localparam int RGB_PXL_W = 16;
  localparam int GS_PXL_W  = 8;

  localparam logic MODE_RGB  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RGB,
    ST_GRAY_LO,
    ST_GRAY_HI
  } state_e;

endpackage

// File: rtl/drc_pxl_fmt_ctrl_if.sv
// Pixel-in / word-out stream bundle of the format controller.
// Signal suffixes are from the controller's point of view.
interface drc_pxl_fmt_ctrl_if;
  import drc_pxl_pkg::*;

  logic [RGB_PXL_W-1:0] rgb_pxl_i;
  logic                 rgb_pxl_last_i;
  logic                 rgb_pxl_vld_i;
  logic                 rgb_pxl_rdy_o;
  logic [RGB_PXL_W-1:0] out_dat_o;
  logic                 out_last_o;
  logic                 out_vld_o;
  logic                 out_rdy_i;

  modport slave (
    input  rgb_pxl_i,
    input  rgb_pxl_last_i,
    input  rgb_pxl_vld_i,
    output rgb_pxl_rdy_o,
    output out_dat_o,
    output out_last_o,
    output out_vld_o,
    input  out_rdy_i
  );

  modport master (
    output rgb_pxl_i,
    output rgb_pxl_last_i,
    output rgb_pxl_vld_i,
    input  rgb_pxl_rdy_o,
    input  out_dat_o,
    input  out_last_o,
    input  out_vld_o,
    output out_rdy_i
  );

endinterface

// File: rtl/drc_pxl_out_reg.sv
// Single-entry valid/ready output slice (data + last).
// Reload on drain gives full throughput with no bubble.
module drc_pxl_out_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] dat_i,
  input  logic         rdy_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic         rdy_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q & ~rdy_i;
    dat_d = dat_q;
    if (load_i) begin
      vld_d = 1'b1;
      dat_d = dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
  assign rdy_o = ~vld_q | rdy_i;

endmodule

// File: rtl/drc_pxl_fmt_ctrl.sv
// Frame-aligned RGB565 / packed-gray output format controller.
// Mode is latched on the first accepted pixel of each frame.
module drc_pxl_fmt_ctrl
  import drc_pxl_pkg::*;
#(
  parameter int FRM_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_gray_en_i,
  output logic                 cfg_mode_o,
  output logic [FRM_CNT_W-1:0] frm_cnt_o,
  output logic [RGB_PXL_W-1:0] cvt_rgb_o,
  input  logic [GS_PXL_W-1:0]  cvt_gs_i,
  drc_pxl_fmt_ctrl_if.slave    px
);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [GS_PXL_W-1:0]  hold_q, hold_d;
  logic [FRM_CNT_W-1:0] cnt_q, cnt_d;

  logic                 rdy;
  logic                 acc;
  logic                 lst;
  logic                 emit;
  logic [RGB_PXL_W-1:0] e_dat;
  logic                 e_last;
  logic [RGB_PXL_W:0]   o_word;

  assign acc = px.rgb_pxl_vld_i & rdy;
  assign lst = px.rgb_pxl_last_i;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    e_dat   = px.rgb_pxl_i;
    e_last  = lst;
    if (acc) begin
      if (lst) cnt_d = cnt_q + FRM_CNT_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          mode_d = cfg_gray_en_i;
          if (cfg_gray_en_i == MODE_RGB) begin
            emit    = 1'b1;
            state_d = lst ? ST_IDLE : ST_RGB;
          end else if (lst) begin
            emit  = 1'b1;
            e_dat = {8'h00, cvt_gs_i};
          end else begin
            hold_d  = cvt_gs_i;
            state_d = ST_GRAY_HI;
          end
        end
        ST_RGB: begin
          emit    = 1'b1;
          state_d = lst ? ST_IDLE : ST_RGB;
        end
        ST_GRAY_HI: begin
          emit    = 1'b1;
          e_dat   = {cvt_gs_i, hold_q};
          state_d = lst ? ST_IDLE : ST_GRAY_LO;
        end
        ST_GRAY_LO: begin
          if (lst) begin
            emit    = 1'b1;
            e_dat   = {8'h00, cvt_gs_i};
            state_d = ST_IDLE;
          end else begin
            hold_d  = cvt_gs_i;
            state_d = ST_GRAY_HI;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_RGB;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  drc_pxl_out_reg #(.W(RGB_PXL_W + 1)) u_out (
    .clk    (clk),
    .rst    (rst),
    .load_i (emit),
    .dat_i  ({e_dat, e_last}),
    .rdy_i  (px.out_rdy_i),
    .vld_o  (px.out_vld_o),
    .dat_o  (o_word),
    .rdy_o  (rdy)
  );

  assign px.out_dat_o     = o_word[RGB_PXL_W:1];
  assign px.out_last_o    = o_word[0];
  assign px.rgb_pxl_rdy_o = rdy;
  assign cvt_rgb_o        = px.rgb_pxl_i;
  assign cfg_mode_o       = mode_q;
  assign frm_cnt_o        = cnt_q;

endmodule

// File: tb/tb_drc_pxl_fmt_ctrl.sv
// Scoreboard bench for the pixel format controller.
// Directed frames push expected words; a monitor pops on each handshake.
module tb_drc_pxl_fmt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_gray_en;
  logic        cfg_mode;
  logic [15:0] frm_cnt;
  logic [15:0] cvt_rgb;
  logic [7:0]  cvt_gs;

  int errs   = 0;
  int checks = 0;

  logic [16:0] sb[$];

  drc_pxl_fmt_ctrl_if pif ();

  drc_pxl_fmt_ctrl #(.FRM_CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_gray_en_i (cfg_gray_en),
    .cfg_mode_o    (cfg_mode),
    .frm_cnt_o     (frm_cnt),
    .cvt_rgb_o     (cvt_rgb),
    .cvt_gs_i      (cvt_gs),
    .px            (pif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && pif.out_vld_o && pif.out_rdy_i) begin
      logic [16:0] e;
      checks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL sb_extra: got %h expected none",
                 {pif.out_dat_o, pif.out_last_o});
      end else begin
        e = sb.pop_front();
        if ({pif.out_dat_o, pif.out_last_o} !== e) begin
          errs++;
          $display("FAIL sb_word: got %h/%b expected %h/%b",
                   pif.out_dat_o, pif.out_last_o, e[16:1], e[0]);
        end
      end
    end
  end

  task automatic send(input logic [15:0] pix, input logic lst,
                      input logic [7:0] gs);
    int n;
    n = 0;
    @(negedge clk);
    pif.rgb_pxl_i      = pix;
    pif.rgb_pxl_last_i = lst;
    pif.rgb_pxl_vld_i  = 1'b1;
    cvt_gs             = gs;
    while (!pif.rgb_pxl_rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got rdy=0 expected rdy=1");
    end
    @(posedge clk);
    #1 pif.rgb_pxl_vld_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    rst               = 1'b1;
    cfg_gray_en       = 1'b0;
    cvt_gs            = 8'h00;
    pif.rgb_pxl_i      = 16'h0;
    pif.rgb_pxl_last_i = 1'b0;
    pif.rgb_pxl_vld_i  = 1'b0;
    pif.out_rdy_i      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld", pif.out_vld_o, 0);
    chk("rst_dat", pif.out_dat_o, 0);
    chk("rst_last", pif.out_last_o, 0);
    chk("rst_mode", cfg_mode, 0);
    chk("rst_frm", frm_cnt, 0);
    chk("rst_rdy", pif.rgb_pxl_rdy_o, 1);
    rst = 1'b0;

    // RGB pass-through frame
    for (int i = 0; i < 4; i++) begin
      sb.push_back({16'h1234 + 16'(i), i == 3});
      send(16'h1234 + 16'(i), i == 3, 8'h00);
    end
    drain();
    chk("rgb_frm", frm_cnt, 1);
    chk("rgb_mode", cfg_mode, 0);
    chk("cvt_rgb", cvt_rgb, 16'h1237);

    // gray even frame
    cfg_gray_en = 1'b1;
    sb.push_back({16'h2010, 1'b0});
    sb.push_back({16'h4030, 1'b1});
    send(16'hF000, 0, 8'h10);
    send(16'hF001, 0, 8'h20);
    send(16'hF002, 0, 8'h30);
    send(16'hF003, 1, 8'h40);
    drain();
    chk("gev_mode", cfg_mode, 1);
    chk("gev_frm", frm_cnt, 2);

    // gray odd frame, then single-pixel gray frame
    sb.push_back({16'hB2A1, 1'b0});
    sb.push_back({16'h00C3, 1'b1});
    send(16'h0001, 0, 8'hA1);
    send(16'h0002, 0, 8'hB2);
    send(16'h0003, 1, 8'hC3);
    sb.push_back({16'h0055, 1'b1});
    send(16'h0004, 1, 8'h55);
    drain();
    chk("god_frm", frm_cnt, 4);

    // mode request changes mid-frame
    cfg_gray_en = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back({16'hA000 + 16'(i), i == 3});
    send(16'hA000, 0, 8'hEE);
    send(16'hA001, 0, 8'hEE);
    cfg_gray_en = 1'b1;
    send(16'hA002, 0, 8'hEE);
    send(16'hA003, 1, 8'hEE);
    drain();
    chk("mid_mode", cfg_mode, 0);
    sb.push_back({16'h2211, 1'b1});
    send(16'hB000, 0, 8'h11);
    send(16'hB001, 1, 8'h22);
    drain();
    chk("nxt_mode", cfg_mode, 1);
    chk("nxt_frm", frm_cnt, 6);

    // backpressure
    cfg_gray_en = 1'b0;
    @(posedge clk);
    #1 pif.out_rdy_i = 1'b0;
    sb.push_back({16'hABCD, 1'b1});
    sb.push_back({16'hBEEF, 1'b1});
    send(16'hABCD, 1, 8'h00);
    repeat (5) begin
      @(negedge clk);
      pif.rgb_pxl_i      = 16'hBEEF;
      pif.rgb_pxl_last_i = 1'b1;
      pif.rgb_pxl_vld_i  = 1'b1;
      chk("bp_rdy", pif.rgb_pxl_rdy_o, 0);
      chk("bp_vld", pif.out_vld_o, 1);
      chk("bp_dat", pif.out_dat_o, 16'hABCD);
    end
    @(posedge clk);
    #1 pif.out_rdy_i = 1'b1;
    @(posedge clk);
    #1 pif.rgb_pxl_vld_i = 1'b0;
    drain();
    chk("bp_frm", frm_cnt, 8);

    // async reset while a low byte is held
    cfg_gray_en = 1'b1;
    sb.push_back({16'h0201, 1'b0});
    send(16'h0011, 0, 8'h01);
    send(16'h0012, 0, 8'h02);
    send(16'h0013, 0, 8'h03);
    rst = 1'b1;
    #1;
    chk("ar_vld", pif.out_vld_o, 0);
    chk("ar_dat", pif.out_dat_o, 0);
    chk("ar_last", pif.out_last_o, 0);
    chk("ar_mode", cfg_mode, 0);
    chk("ar_frm", frm_cnt, 0);
    chk("ar_rdy", pif.rgb_pxl_rdy_o, 1);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back({16'h0099, 1'b1});
    send(16'h0014, 1, 8'h99);
    drain();
    chk("ar_frm1", frm_cnt, 1);

    // frame counter wrap
    cfg_gray_en = 1'b0;
    for (int i = 0; i < 65534; i++) begin
      sb.push_back({16'(i), 1'b1});
      send(16'(i), 1, 8'h00);
    end
    drain();
    chk("wrap_max", frm_cnt, 16'hFFFF);
    sb.push_back({16'h7777, 1'b1});
    send(16'h7777, 1, 8'h00);
    drain();
    chk("wrap_zero", frm_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/drc_pxl_fmt_ctrl.md
# drc_pxl_fmt_ctrl

Frame-aligned output-format controller for the DVP RX pixel path. It accepts the RGB565 pixel stream with its last-of-frame flag and selects, once per frame, between RGB565 pass-through and grayscale. In grayscale mode it routes each pixel through the external combinational RGB565→gray converter and packs two 8-bit gray pixels into one 16-bit output word. It sits between the RGB pixel source and the downstream 16-bit pixel FIFO/DMA interface.

## Interface
- RGB_PXL_W, 16, RGB565 pixel width (fixed, do not configure)
- GS_PXL_W, 8, gray pixel width (fixed, do not configure)
- FRM_CNT_W, 16, width of the completed-frame counter

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_gray_en_i  in  1  requested mode: 1 = gray packed, 0 = RGB565; sampled only at frame start
- cfg_mode_o  out  1  mode of the current (or most recent) frame
- frm_cnt_o  out  FRM_CNT_W  completed frames, wraps
- rgb_pxl_i  in  16  input RGB565 pixel
- rgb_pxl_last_i  in  1  last pixel of frame
- rgb_pxl_vld_i  in  1  input valid
- rgb_pxl_rdy_o  out  1  input ready
- cvt_rgb_o  out  16  pixel to converter; always equals rgb_pxl_i
- cvt_gs_i  in  8  gray result from converter, same cycle
- out_dat_o  out  16  output word
- out_last_o  out  1  last word of frame
- out_vld_o  out  1  output valid
- out_rdy_i  in  1  output ready

## Operation
- Accept = rgb_pxl_vld_i & rgb_pxl_rdy_o. rgb_pxl_rdy_o = !out_vld_o | out_rdy_i (combinational, independent of rgb_pxl_vld_i).
- States: IDLE (awaiting first pixel of a frame), RGB, GRAY_LO (next pixel goes to the low byte), GRAY_HI (low byte held, next pixel goes to the high byte). All transitions occur only on accept.
- IDLE on accept: cfg_mode_o <= cfg_gray_en_i. RGB case: load output {rgb_pxl_i}; go to RGB. Gray case: hold <= cvt_gs_i; go to GRAY_HI. If last is set: RGB emits a word with last = 1; gray emits {8'h00, cvt_gs_i} with last = 1; both return to IDLE.
- RGB on accept: emit rgb_pxl_i with out_last_o = rgb_pxl_last_i; go to IDLE if last, else stay in RGB.
- GRAY_HI on accept: emit {cvt_gs_i, hold} (first pixel in [7:0]); go to IDLE if last, else GRAY_LO.
- GRAY_LO on accept: hold <= cvt_gs_i and go to GRAY_HI. If last: emit {8'h00, cvt_gs_i} with last = 1 and go to IDLE.
- Changes on cfg_gray_en_i mid-frame are ignored until the next IDLE accept.
- frm_cnt_o increments on the accept of any pixel with last set; wraps from 2^FRM_CNT_W-1 to 0.
- Output register: out_vld_o is set on an emit. It clears on out_rdy_i when no new emit occurs in the same cycle. Emit and drain in the same cycle reloads the register with no bubble.
- Data and last stay stable while out_vld_o = 1 and out_rdy_i = 0.

## Timing
- Reset values: out_vld_o = 0, out_dat_o = 0, out_last_o = 0, cfg_mode_o = 0, frm_cnt_o = 0, hold = 0, state = IDLE. rgb_pxl_rdy_o = 1 after reset.
- Latency from accept to out_vld_o is 1 cycle for an emitting accept.
- Throughput: RGB is 1 pixel/cycle. Gray is 1 word per 2 pixels at 1 pixel/cycle input.
- Backpressure: out_rdy_i = 0 with out_vld_o = 1 forces rgb_pxl_rdy_o = 0 in all states, including non-emitting states.
- Reset mid-frame drops any held low byte and the output word. The next accepted pixel is treated as a frame start.

## Structure
- Shared package/header drc_pxl_pkg: state encoding (IDLE, RGB, GRAY_LO, GRAY_HI), mode constants (MODE_RGB = 0, MODE_GRAY = 1), and the RGB_PXL_W/GS_PXL_W widths.
- One sub-module, drc_pxl_out_reg: a 17-bit (data + last) valid/ready output register slice.
- The FSM, hold register and frame counter live in the top module.
- The converter stays external.

## Test plan
- RGB frame: cfg = 0, 4 pixels 16'h1234..16'h1237 with last on the 4th, out_rdy_i = 1. Expect 4 words identical to the input, last on the 4th only, frm_cnt_o = 1, output 1 cycle after each accept.
- Gray even frame: cfg = 1, converter returns 8'h10, 8'h20, 8'h30, 8'h40. Expect words 16'h2010 and 16'h4030 (last = 1 on the second), cfg_mode_o = 1.
- Gray odd frame: 3 pixels giving 8'hA1, 8'hB2, 8'hC3. Expect 16'hB2A1, then 16'h00C3 with last = 1. A single-pixel gray frame with 8'h55 gives 16'h0055 with last = 1.
- Mode change mid-frame: toggle cfg_gray_en_i after pixel 2 of an RGB frame. Expect the frame to stay RGB and the next frame to switch to gray.
- Backpressure: hold out_rdy_i = 0 for 5 cycles with out_vld_o = 1. Expect rgb_pxl_rdy_o = 0 and out_dat_o stable, with no loss or duplication after release. Then 65536 single-pixel frames wrap frm_cnt_o to 0.
- Async reset asserted while in GRAY_HI: outputs return to reset values immediately. The next pixel starts a new frame with its gray value in the low byte.
